// File: rtl/md_sched.sv
// md_sched: LCU scheduler ping-ponging two pixel banks between the loader and the mode-decision engine
// Ports: clk/rstn (sync, active low); start/lcu_total begin a frame; ld_req/ld_bank/ld_done drive
// the bank loader; md_enable/md_bank/md_finish and bestmode*_i drive the engine; res_valid/res_ready/
// res_data form the first-word-fall-through result stream; busy/done report frame progress.
module md_sched #(
  parameter int RES_DEPTH = 4,
  parameter int IDX_W = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [IDX_W-1:0]   lcu_total,
  output logic               ld_req,
  output logic               ld_bank,
  input  logic               ld_done,
  output logic               md_enable,
  output logic               md_bank,
  input  logic               md_finish,
  input  logic [5:0]         bestmode_i,
  input  logic [5:0]         bestmode16_i,
  input  logic [5:0]         bestmode32_i,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [IDX_W+17:0]  res_data,
  output logic               busy,
  output logic               done
);
  localparam int AW = $clog2(RES_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RES_DEPTH);
  typedef enum logic {L_IDLE, L_REQ} ld_st_t;
  typedef enum logic {M_IDLE, M_RUN} md_st_t;
  ld_st_t ld_st_q;
  md_st_t md_st_q;
  logic [1:0] full_q, full_d;
  logic ld_ptr_q, md_ptr_q;
  logic [IDX_W-1:0] total_q, ld_cnt_q, md_cnt_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] fifo_cnt_q;
  logic [IDX_W+17:0] mem_q [RES_DEPTH];
  logic ld_fin, md_fin, pop;
  assign ld_fin = ld_st_q == L_REQ && ld_done;
  assign md_fin = md_st_q == M_RUN && md_finish;
  assign res_valid = fifo_cnt_q != '0;
  assign pop = res_valid && res_ready;
  assign res_data = res_valid ? mem_q[rd_q] : '0;
  // Loader and engine own different banks, so both bit updates can land in the same cycle.
  always_comb begin
    full_d = full_q;
    if (ld_fin) full_d[ld_bank] = 1'b1;
    if (md_fin) full_d[md_bank] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ld_st_q <= L_IDLE;
      md_st_q <= M_IDLE;
      full_q <= '0;
      ld_ptr_q <= 1'b0;
      md_ptr_q <= 1'b0;
      total_q <= '0;
      ld_cnt_q <= '0;
      md_cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      fifo_cnt_q <= '0;
      ld_req <= 1'b0;
      ld_bank <= 1'b0;
      md_enable <= 1'b0;
      md_bank <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      md_enable <= 1'b0;
      full_q <= full_d;
      fifo_cnt_q <= fifo_cnt_q + CW'(md_fin) - CW'(pop);
      if (md_fin) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      if (!busy && start) begin
        busy <= 1'b1;
        total_q <= lcu_total;
        ld_cnt_q <= '0;
        md_cnt_q <= '0;
      end else if (busy && md_cnt_q == total_q && fifo_cnt_q == '0) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      if (ld_st_q == L_IDLE) begin
        if (busy && !full_q[ld_ptr_q] && ld_cnt_q < total_q) begin
          ld_st_q <= L_REQ;
          ld_req <= 1'b1;
          ld_bank <= ld_ptr_q;
        end
      end else if (ld_done) begin
        ld_st_q <= L_IDLE;
        ld_req <= 1'b0;
        ld_ptr_q <= ~ld_ptr_q;
        ld_cnt_q <= ld_cnt_q + 1'b1;
      end
      // One run in flight plus a free slot at launch means every push finds room.
      if (md_st_q == M_IDLE) begin
        if (busy && full_q[md_ptr_q] && md_cnt_q < total_q && fifo_cnt_q < FULL_CNT) begin
          md_st_q <= M_RUN;
          md_enable <= 1'b1;
          md_bank <= md_ptr_q;
        end
      end else if (md_finish) begin
        md_st_q <= M_IDLE;
        md_ptr_q <= ~md_ptr_q;
        md_cnt_q <= md_cnt_q + 1'b1;
      end
    end
  end
  // md_cnt doubles as the LCU index of the run being retired.
  always_ff @(posedge clk) begin
    if (md_fin) mem_q[wr_q] <= {md_cnt_q, bestmode32_i, bestmode16_i, bestmode_i};
  end
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: randomized self-checking bench for md_sched against a transaction-level scheduler model
module tb_md_sched;
  localparam int IDX_W = 8;
  localparam int DEPTH = 4;
  localparam int DW = IDX_W + 18;
  logic clk, rstn, start, ld_done, md_finish, res_ready;
  logic [IDX_W-1:0] lcu_total;
  logic ld_req, ld_bank, md_enable, md_bank, res_valid, busy, done;
  logic [5:0] b8, b16, b32;
  logic [DW-1:0] res_data;
  md_sched #(.RES_DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .lcu_total(lcu_total),
    .ld_req(ld_req), .ld_bank(ld_bank), .ld_done(ld_done),
    .md_enable(md_enable), .md_bank(md_bank), .md_finish(md_finish),
    .bestmode_i(b8), .bestmode16_i(b16), .bestmode32_i(b32),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .done(done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, cyc = 0, frames = 0, n_en = 0;
  int ld_lat_cfg = 5, md_lat_cfg = 10, rdy_mode = 0;
  bit spur_en = 0;
  bit busy_m, fin_q, ld_pend, md_pend, ld_req_m, md_run, rst_seen;
  bit ld_par, md_par, ld_bank_exp, md_bank_exp;
  bit [1:0] fullm;
  int total_m, loads, runs, npop, ld_due, md_due, done_due, ld_t, md_t;
  logic [DW-1:0] q[$];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic model_reset();
    busy_m = 0; fin_q = 0; ld_pend = 0; md_pend = 0; ld_req_m = 0; md_run = 0;
    ld_par = 0; md_par = 0; ld_bank_exp = 0; md_bank_exp = 0; fullm = '0;
    total_m = 0; loads = 0; runs = 0; npop = 0;
    ld_due = -1; md_due = -1; done_due = -1; ld_t = -1; md_t = -1;
    q.delete();
  endtask
  // Each sample k sees outputs after edge k and sets inputs consumed at edge k+1;
  // a rule that becomes true in the model at sample j shows up on the outputs at sample j+2.
  initial begin
    ld_done = 0; md_finish = 0; res_ready = 0; b8 = 0; b16 = 0; b32 = 0; rst_seen = 0;
    model_reset();
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_seen) begin
        check("rst_ld_bank", 64'(ld_bank), 0);
        check("rst_md_bank", 64'(md_bank), 0);
        check("rst_res_data", 64'(res_data), 0);
        rst_seen = 0;
      end
      check("busy", 64'(busy), 64'(busy_m));
      check("done", 64'(done), 64'(cyc == done_due));
      if (done) frames++;
      if (cyc == done_due) check("pop_count", 64'(npop), 64'(total_m));
      if (cyc == ld_due) ld_req_m = 1;
      check("ld_req", 64'(ld_req), 64'(ld_req_m));
      if (cyc == ld_due) check("ld_bank", 64'(ld_bank), 64'(ld_bank_exp));
      check("md_enable", 64'(md_enable), 64'(cyc == md_due));
      if (md_enable) n_en++;
      if (cyc == md_due) begin
        check("md_bank", 64'(md_bank), 64'(md_bank_exp));
        md_run = 1;
        md_t = md_lat_cfg < 0 ? int'($urandom_range(0, 6)) : md_lat_cfg;
      end
      check("res_valid", 64'(res_valid), 64'(q.size() != 0));
      if (q.size() != 0) check("res_data", 64'(res_data), 64'(q[0]));
      ld_done = 0; md_finish = 0; res_ready = 0;
      b8 = 6'($urandom); b16 = 6'($urandom); b32 = 6'($urandom);
      if (!rstn) begin
        model_reset();
        rst_seen = 1;
        continue;
      end
      if (fin_q) begin
        busy_m = 0; fin_q = 0; done_due = cyc + 1;
      end else if (start && !busy_m) begin
        busy_m = 1; total_m = int'(lcu_total); loads = 0; runs = 0; npop = 0; n_en = 0;
      end
      res_ready = rdy_mode == 0 || (rdy_mode == 1 && $urandom_range(0, 1) == 1);
      if (res_ready && q.size() != 0) begin
        void'(q.pop_front());
        npop++;
      end
      if (ld_req_m) begin
        if (ld_t < 0) ld_t = ld_lat_cfg < 0 ? int'($urandom_range(0, 6)) : ld_lat_cfg;
        if (ld_t == 0) begin
          ld_done = 1; ld_req_m = 0; ld_pend = 0; ld_t = -1;
          fullm[ld_bank_exp] = 1; ld_par = ~ld_par; loads++;
        end else ld_t--;
      end else if (spur_en && $urandom_range(0, 7) == 0) ld_done = 1;
      if (md_run) begin
        if (md_t == 0) begin
          md_finish = 1;
          check("md_bank_hold", 64'(md_bank), 64'(md_bank_exp));
          q.push_back({IDX_W'(runs), b32, b16, b8});
          fullm[md_bank_exp] = 0; md_par = ~md_par; runs++; md_pend = 0; md_run = 0;
        end else md_t--;
      end else if (spur_en && $urandom_range(0, 7) == 0) md_finish = 1;
      if (busy_m && !ld_pend && !fullm[ld_par] && loads < total_m) begin
        ld_pend = 1; ld_bank_exp = ld_par; ld_due = cyc + 2;
      end
      if (busy_m && !md_pend && fullm[md_par] && runs < total_m && q.size() < DEPTH) begin
        md_pend = 1; md_bank_exp = md_par; md_due = cyc + 2;
      end
      if (busy_m && runs == total_m && q.size() == 0) fin_q = 1;
    end
  end
  task automatic do_start(input int n);
    @(posedge clk); #2;
    start = 1; lcu_total = IDX_W'(n);
    @(posedge clk); #2;
    start = 0;
  endtask
  task automatic wait_done(input int f0, input int budget);
    for (int i = 0; i < budget && frames == f0; i++) @(posedge clk);
    check("frame_done", 64'(frames), 64'(f0 + 1));
  endtask
  task automatic run_frame(input int n, input int budget);
    int f0;
    f0 = frames;
    do_start(n);
    wait_done(f0, budget);
  endtask
  initial begin
    int f0;
    rstn = 0; start = 0; lcu_total = '0;
    repeat (3) @(posedge clk);
    #2 rstn = 1;
    run_frame(1, 400);
    ld_lat_cfg = 1; md_lat_cfg = 40;
    run_frame(4, 600);
    ld_lat_cfg = 0; md_lat_cfg = 2; rdy_mode = 2;
    f0 = frames;
    do_start(6);
    repeat (200) @(posedge clk);
    check("stall_enables", 64'(n_en), 4);
    rdy_mode = 0;
    wait_done(f0, 400);
    ld_lat_cfg = 3; md_lat_cfg = 3;
    run_frame(4, 400);
    run_frame(0, 20);
    ld_lat_cfg = 2; md_lat_cfg = 8;
    f0 = frames;
    do_start(3);
    repeat (10) @(posedge clk);
    do_start(5);
    wait_done(f0, 400);
    ld_lat_cfg = 3; md_lat_cfg = 20;
    f0 = frames;
    do_start(4);
    for (int i = 0; i < 200 && !(ld_req && md_run); i++) begin
      @(posedge clk); #1;
    end
    check("rst_setup", 64'(ld_req && md_run), 1);
    #1 rstn = 0;
    @(posedge clk); #2;
    rstn = 1;
    repeat (20) @(posedge clk);
    check("no_done_after_rst", 64'(frames), 64'(f0));
    run_frame(2, 400);
    ld_lat_cfg = -1; md_lat_cfg = -1; rdy_mode = 1; spur_en = 1;
    for (int i = 0; i < 8; i++) run_frame(int'($urandom_range(0, 9)), 1500);
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- LCU-level scheduler for the pre-intra mode-decision engine.
- Owns a ping-pong pair of pixel SRAM banks. Sequences the external loader (fill) and the mode-decision engine (enable/finish) across a frame of LCUs, overlapping the load of one LCU with the decision of the previous one.
- Packs each LCU's bestmode/bestmode16/bestmode32 with the LCU index into a small result FIFO for the downstream consumer.

Parameters:
- RES_DEPTH, 4, result FIFO depth in entries (power of 2, ≥2).
- IDX_W, 8, LCU index / count width.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous reset, active low
- start  in  1  frame start pulse; ignored while busy
- lcu_total  in  IDX_W  LCUs in frame; sampled on accepted start
- ld_req  out  1  level; request loader to fill bank ld_bank
- ld_bank  out  1  bank the loader writes
- ld_done  in  1  pulse; loader finished current fill
- md_enable  out  1  one-cycle start pulse to mode-decision engine
- md_bank  out  1  bank the engine reads; stable from md_enable to md_finish
- md_finish  in  1  pulse; engine done, mode inputs valid this cycle
- bestmode_i  in  6  8x8-level best mode
- bestmode16_i  in  6  16x16 best mode
- bestmode32_i  in  6  32x32 best mode
- res_valid  out  1  FIFO non-empty
- res_ready  in  1  consumer accepts head entry
- res_data  out  IDX_W+18  {lcu_idx, bestmode32, bestmode16, bestmode}
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset (rstn=0 at posedge): all outputs 0; full[1:0]=0; ld_ptr=md_ptr=0; all counters 0; FIFO emptied; both sub-FSMs IDLE. Reset mid-frame aborts with no done pulse.
- start accepted only when busy=0. Latches lcu_total, clears ld_cnt/md_cnt/lcu_idx. busy=1 from the next cycle.
- Loader FSM:
  - States L_IDLE, L_REQ.
  - L_IDLE→L_REQ when busy, full[ld_ptr]=0 and ld_cnt<total. ld_req=1 and ld_bank=ld_ptr, registered.
  - In L_REQ, ld_done sets full[ld_bank], toggles ld_ptr, increments ld_cnt, returns to L_IDLE. ld_req is low the following cycle.
  - Earliest re-request: ld_done in cycle N → ld_req high again in N+2.
- MD FSM:
  - States M_IDLE, M_RUN.
  - M_IDLE→M_RUN when busy, full[md_ptr]=1, md_cnt<total and fifo_cnt<RES_DEPTH. md_enable=1 for exactly that one cycle; md_bank=md_ptr.
  - ld_done in cycle N → md_enable at the earliest in cycle N+2.
  - In M_RUN, md_finish pushes {lcu_idx, modes}, clears full[md_bank], toggles md_ptr, increments md_cnt and lcu_idx, returns to M_IDLE. Next md_enable no earlier than 2 cycles after md_finish.
- ld_done outside L_REQ and md_finish outside M_RUN are ignored.
- Loader and engine always touch different banks: the loader fills only empty banks and the engine runs only on full ones. Same-cycle ld_done and md_finish update independent full bits, and both take effect.
- Result FIFO:
  - First-word-fall-through; res_valid=(fifo_cnt≠0); pop on res_valid&res_ready.
  - No bypass: a push into an empty FIFO is visible the next cycle.
  - Push and pop in the same cycle leaves fifo_cnt unchanged.
  - The start condition guarantees space on every push, so no overflow. Consumer backpressure stalls further md_enable.
- Completion: when md_cnt==total and fifo_cnt==0 with busy=1, done=1 for one cycle and busy=0 in that same cycle.
- lcu_total=0: busy high one cycle, then done; no ld_req, no md_enable.
- Counters are IDX_W wide. lcu_idx runs 0..total-1 and never wraps within a frame.

Test Plan:
- Reset, then start with lcu_total=1; loader answers ld_done 5 cycles after ld_req, engine answers md_finish 10 cycles after md_enable, res_ready=1 → required: one ld_req, one md_enable on bank 0, res_data={0,modes}, done pulse, busy low.
- lcu_total=4 with fast loader and slow engine (finish 40 cycles after enable) → required: second ld_req overlaps the first MD run; ld_req stalls while both banks are full; md_bank alternates 0,1,0,1; results carry idx 0..3 in order.
- res_ready=0 with lcu_total=6, RES_DEPTH=4 → required: exactly 4 md_enable pulses then stall; after ready is raised, the remaining 2 runs complete; 6 entries emerge in order; no overflow.
- ld_done and md_finish in the same cycle → required: both full-bit updates take effect; no lost load or result.
- lcu_total=0 → required: done one cycle after busy, no requests. Start asserted while busy → required: ignored.
- rstn low mid-frame while in L_REQ/M_RUN → required: all outputs 0 next cycle, FIFO empty, no done pulse; a new start runs cleanly.
